// File: rtl/sar_adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_adc_pkg
//  Description : Shared types and constants for the SAR ADC sequencer:
//                FSM state encoding, default parameter values and the
//                comparator-trim midscale reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
package sar_adc_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SAMPLE    = 3'd1,
        S_CONVERT   = 3'd2,
        S_EOC       = 3'd3,
        S_CAL_SHORT = 3'd4,
        S_CAL_SAR   = 3'd5
    } sar_state_e;

    localparam int DEF_DATA_W        = 8;
    localparam int DEF_TRIM_W        = 5;
    localparam int DEF_SAMPLE_CYCLES = 4;
    localparam int DEF_EOC_CYCLES    = 2;

    // Midscale trim for the default trim width
    localparam logic [DEF_TRIM_W-1:0] TRIM_MID = {1'b1, {(DEF_TRIM_W-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search
//  Description : Generic W-bit successive-approximation register.
//                start_i loads the first trial (MSB only), each step_i
//                resolves the current trial bit from comp_i and sets the next
//                lower bit as the following trial. done_o flags the step that
//                resolves bit 0. clear_i returns the code to RST_VAL.
//  Ports       : clk, rst (async, active high), clear_i, start_i, step_i,
//                comp_i, code_o [W-1:0], done_o
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_search
    import sar_adc_pkg::*;
#(
    parameter int           W       = DEF_DATA_W,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         start_i,
    input  logic         step_i,
    input  logic         comp_i,
    output logic [W-1:0] code_o,
    output logic         done_o
);

    localparam int               IDX_W     = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] c_IDX_TOP = IDX_W'(W - 1);

    logic [W-1:0]     code_q, code_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        code_d = code_q;
        idx_d  = idx_q;
        done_o = 1'b0;
        if (clear_i) begin
            code_d = RST_VAL;
            idx_d  = '0;
        end else if (start_i) begin
            code_d        = '0;
            code_d[W-1]   = 1'b1;
            idx_d         = c_IDX_TOP;
        end else if (step_i) begin
            // Comparator low means the trial overshot: drop the bit
            if (!comp_i) begin
                code_d[idx_q] = 1'b0;
            end
            if (idx_q != '0) begin
                code_d[idx_q - 1'b1] = 1'b1;
                idx_d                = idx_q - 1'b1;
            end else begin
                done_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= RST_VAL;
            idx_q  <= '0;
        end else begin
            code_q <= code_d;
            idx_q  <= idx_d;
        end
    end

    assign code_o = code_q;

endmodule
`default_nettype wire

// File: rtl/sar_adc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sar_adc_seq
//  Description : SAR conversion sequencer (analog clock domain). Controls the
//                sample switch, capacitive-DAC trial code and comparator
//                offset trim; returns an 8-bit result with an active-low
//                end-of-conversion strobe.
//  Ports       : clk, rst (async, active high)
//                adc_en_i, firmware_en_i, calib_en_i, comp_i      (inputs)
//                sample_o, cal_short_o, dac_code_o, trim_o,
//                adc_data_o, adc_eoc_n_o, busy_o                  (outputs)
//  Options     : SAR_ADC_AVG_EN - each result averages 4 conversions
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_adc_seq
    import sar_adc_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int TRIM_W        = DEF_TRIM_W,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int EOC_CYCLES    = DEF_EOC_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_en_i,
    input  logic              firmware_en_i,
    input  logic              calib_en_i,
    input  logic              comp_i,
    output logic              sample_o,
    output logic              cal_short_o,
    output logic [DATA_W-1:0] dac_code_o,
    output logic [TRIM_W-1:0] trim_o,
    output logic [DATA_W-1:0] adc_data_o,
    output logic              adc_eoc_n_o,
    output logic              busy_o
);

    localparam logic [TRIM_W-1:0] c_TRIM_MID    = {1'b1, {(TRIM_W-1){1'b0}}};
    localparam logic [7:0]        c_SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
    localparam logic [7:0]        c_EOC_LAST    = 8'(EOC_CYCLES - 1);

    sar_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              cal_pend_q, cal_pend_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              en_prev_q, cal_prev_q;

    logic              w_en_rise, w_cal_rise, w_cal_req;
    logic              w_dac_clear, w_dac_start, w_dac_step, w_dac_done;
    logic              w_trim_start, w_trim_step, w_trim_done;
    logic [DATA_W-1:0] w_dac_final;

    assign w_en_rise  = adc_en_i & ~en_prev_q;
    assign w_cal_rise = calib_en_i & ~cal_prev_q;
    assign w_cal_req  = cal_pend_q | w_cal_rise;

    // On the step that resolves bit 0 the upper bits are final and the LSB
    // is decided by the comparator directly.
    assign w_dac_final = {dac_code_o[DATA_W-1:1], comp_i};

`ifdef SAR_ADC_AVG_EN
    logic [DATA_W+1:0] acc_q, acc_d;
    logic [1:0]        avg_cnt_q, avg_cnt_d;
    logic [DATA_W+1:0] w_sum;

    assign w_sum = acc_q + {2'b00, w_dac_final};
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cal_pend_d   = cal_pend_q;
        data_d       = data_q;
        w_dac_clear  = 1'b0;
        w_dac_start  = 1'b0;
        w_dac_step   = 1'b0;
        w_trim_start = 1'b0;
        w_trim_step  = 1'b0;
`ifdef SAR_ADC_AVG_EN
        acc_d        = acc_q;
        avg_cnt_d    = avg_cnt_q;
`endif
        // Requests seen while busy are remembered; repeats collapse into one
        if (w_cal_rise && (state_q != S_IDLE)) begin
            cal_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_cal_req) begin
                    state_d    = S_CAL_SHORT;
                    cnt_d      = '0;
                    cal_pend_d = 1'b0;
                end else if (adc_en_i && (!firmware_en_i || w_en_rise)) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end
            end
            S_SAMPLE, S_CONVERT: begin
                if (!adc_en_i) begin
                    state_d     = S_IDLE;
                    w_dac_clear = 1'b1;
`ifdef SAR_ADC_AVG_EN
                    acc_d       = '0;
                    avg_cnt_d   = '0;
`endif
                end else if (state_q == S_SAMPLE) begin
                    if (cnt_q == c_SAMPLE_LAST) begin
                        state_d     = S_CONVERT;
                        w_dac_start = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    w_dac_step = 1'b1;
                    if (w_dac_done) begin
                        cnt_d = '0;
`ifdef SAR_ADC_AVG_EN
                        if (avg_cnt_q == 2'd3) begin
                            data_d    = w_sum[DATA_W+1:2];
                            acc_d     = '0;
                            avg_cnt_d = '0;
                            state_d   = S_EOC;
                        end else begin
                            acc_d     = w_sum;
                            avg_cnt_d = avg_cnt_q + 2'd1;
                            state_d   = S_SAMPLE;
                        end
`else
                        data_d  = w_dac_final;
                        state_d = S_EOC;
`endif
                    end
                end
            end
            S_EOC: begin
                if (cnt_q == c_EOC_LAST) begin
                    cnt_d = '0;
                    if (adc_en_i && !firmware_en_i && !w_cal_req) begin
                        state_d = S_SAMPLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CAL_SHORT: begin
                if (cnt_q == c_SAMPLE_LAST) begin
                    state_d      = S_CAL_SAR;
                    w_trim_start = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CAL_SAR: begin
                w_trim_step = 1'b1;
                if (w_trim_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cal_pend_q <= 1'b0;
            data_q     <= '0;
            en_prev_q  <= 1'b0;
            cal_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cal_pend_q <= cal_pend_d;
            data_q     <= data_d;
            en_prev_q  <= adc_en_i;
            cal_prev_q <= calib_en_i;
        end
    end

`ifdef SAR_ADC_AVG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            avg_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            avg_cnt_q <= avg_cnt_d;
        end
    end
`endif

    sar_search #(
        .W       (DATA_W),
        .RST_VAL ('0)
    ) u_dac_sar (
        .clk     (clk),
        .rst     (rst),
        .clear_i (w_dac_clear),
        .start_i (w_dac_start),
        .step_i  (w_dac_step),
        .comp_i  (comp_i),
        .code_o  (dac_code_o),
        .done_o  (w_dac_done)
    );

    sar_search #(
        .W       (TRIM_W),
        .RST_VAL (c_TRIM_MID)
    ) u_trim_sar (
        .clk     (clk),
        .rst     (rst),
        .clear_i (1'b0),
        .start_i (w_trim_start),
        .step_i  (w_trim_step),
        .comp_i  (comp_i),
        .code_o  (trim_o),
        .done_o  (w_trim_done)
    );

    // Switch controls decode straight from the state register
    assign sample_o    = (state_q == S_SAMPLE);
    assign cal_short_o = (state_q == S_CAL_SHORT) || (state_q == S_CAL_SAR);
    assign adc_eoc_n_o = (state_q != S_EOC);
    assign busy_o      = (state_q != S_IDLE);
    assign adc_data_o  = data_q;

endmodule
`default_nettype wire
